// File: rtl/serial_word_receiver_if.sv
// Handshake/data bundle between a serial transmitter/consumer and serial_word_receiver.
// parity_err exists only when SERIAL_WORD_RECEIVER_PARITY_EN is defined.
interface serial_word_receiver_if #(parameter int WIDTH = 12);
  logic             frame_start;
  logic             shift;
  logic             serial_data_in;
  logic             data_ready;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             overrun;
  logic             frame_err;
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
  logic             parity_err;
`endif

  modport master (
    output frame_start, shift, serial_data_in, data_ready,
    input  data_out, data_valid, overrun, frame_err
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
    , input parity_err
`endif
  );

  modport slave (
    input  frame_start, shift, serial_data_in, data_ready,
    output data_out, data_valid, overrun, frame_err
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
    , output parity_err
`endif
  );
endinterface

// File: rtl/serial_word_receiver.sv
// MSB-first serial word receiver with a one-deep output register; optional trailing
// even-parity bit when SERIAL_WORD_RECEIVER_PARITY_EN is defined.
// state | meaning
// IDLE  | no frame open, shifts ignored
// RECV  | frame open, bit counter active
module serial_word_receiver #(
  parameter int WIDTH = 12
) (
  input logic                   clk,
  input logic                   rst_n,
  serial_word_receiver_if.slave bus
);
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
  localparam int N = WIDTH + 1;
`else
  localparam int N = WIDTH;
`endif
  localparam int CNT_W = $clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic {IDLE, RECV} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  // Only the first N-1 bits are stored; the final bit is taken straight from the line.
  logic [N-2:0]     sreg, sreg_nxt;
  logic [N-1:0]     frame_word;
  logic             done;
  logic             abort;
  logic [WIDTH-1:0] word_nxt;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             overrun_q;
  logic             frame_err_q;

  assign frame_word = {sreg, bus.serial_data_in};

`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
  logic perr_nxt;
  logic perr_q;
  assign word_nxt       = frame_word[N-1:1];
  assign perr_nxt       = ^frame_word;
  assign bus.parity_err = perr_q;
`else
  assign word_nxt = frame_word;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      sreg  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sreg  <= sreg_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sreg_nxt  = sreg;
    done      = 1'b0;
    abort     = 1'b0;
    if (bus.frame_start) begin
      abort     = (state == RECV) && (cnt != '0);
      state_nxt = RECV;
      cnt_nxt   = bus.shift ? CNT_W'(1) : '0;
      sreg_nxt  = bus.shift ? {{(N-2){1'b0}}, bus.serial_data_in} : '0;
    end else if (state == RECV && bus.shift) begin
      if (cnt == LAST) begin
        done      = 1'b1;
        state_nxt = IDLE;
        cnt_nxt   = '0;
        sreg_nxt  = '0;
      end else begin
        cnt_nxt  = cnt + 1'b1;
        sreg_nxt = {sreg[N-3:0], bus.serial_data_in};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
      perr_q      <= 1'b0;
`endif
    end else begin
      overrun_q   <= 1'b0;
      frame_err_q <= abort;
      if (done && (!valid_q || bus.data_ready)) begin
        data_q  <= word_nxt;
        valid_q <= 1'b1;
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
        perr_q  <= perr_nxt;
`endif
      end else begin
        // A completed word with a full, unaccepted output register is dropped.
        if (done) overrun_q <= 1'b1;
        if (valid_q && bus.data_ready) valid_q <= 1'b0;
      end
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.overrun    = overrun_q;
  assign bus.frame_err  = frame_err_q;
endmodule

// File: tb/tb_serial_word_receiver.sv
// Scoreboard bench for serial_word_receiver: expected words queued as frames are sent,
// popped and compared when data_valid is seen.
`timescale 1ns/1ps
module tb_serial_word_receiver;
  localparam int WIDTH = 12;
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
  localparam int FN = WIDTH + 1;
`else
  localparam int FN = WIDTH;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   ovr_cnt  = 0;
  int   ferr_cnt = 0;
  logic [WIDTH:0] exp_q[$];   // {parity_err, data}
  logic [WIDTH:0] exp_e;

  serial_word_receiver_if #(.WIDTH(WIDTH)) bus();
  serial_word_receiver #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.overrun === 1'b1) ovr_cnt++;
    if (bus.frame_err === 1'b1) ferr_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FN-1:0] make_frame(input logic [WIDTH-1:0] w, input logic par);
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
    return {w, par};
`else
    return w;
`endif
  endfunction

  function automatic logic [WIDTH:0] make_exp(input logic [WIDTH-1:0] w, input logic par);
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
    return {(^w) ^ par, w};
`else
    return {1'b0, w};
`endif
  endfunction

  task automatic send_bits(input logic [FN-1:0] frame, input int nbits, input bit start,
                           input logic rdy_last);
    for (int k = 0; k < nbits; k++) begin
      bus.frame_start    = start && (k == 0);
      bus.shift          = 1'b1;
      bus.serial_data_in = frame[FN-1-k];
      if (k == nbits - 1) bus.data_ready = rdy_last;
      tick();
    end
    bus.frame_start    = 1'b0;
    bus.shift          = 1'b0;
    bus.serial_data_in = 1'b0;
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input logic rdy_last, input bit expect_out);
    if (expect_out) exp_q.push_back(make_exp(w, ^w));
    send_bits(make_frame(w, ^w), FN, 1'b1, rdy_last);
  endtask

  task automatic check_output(input string name);
    n_checks++;
    if (bus.data_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_valid: data_valid=%b expected 1", name, bus.data_valid);
    end else if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s_queue: data_out=%h produced with no expected word queued", name, bus.data_out);
    end else begin
      exp_e = exp_q.pop_front();
      n_checks++;
      if (bus.data_out !== exp_e[WIDTH-1:0]) begin
        n_fail++;
        $display("FAIL %s_data: data_out=%h expected %h", name, bus.data_out, exp_e[WIDTH-1:0]);
      end
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
      n_checks++;
      if (bus.parity_err !== exp_e[WIDTH]) begin
        n_fail++;
        $display("FAIL %s_parity: parity_err=%b expected %b", name, bus.parity_err, exp_e[WIDTH]);
      end
`endif
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.frame_start = 1'b1; bus.shift = 1'b1; bus.serial_data_in = 1'b1; bus.data_ready = 1'b1;
    tick(); tick();
    bus.frame_start = 1'b0; bus.shift = 1'b0; bus.serial_data_in = 1'b0; bus.data_ready = 1'b0;
    n_checks++;
    if (bus.data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.data_valid); end
    n_checks++;
    if (bus.data_out !== '0) begin n_fail++; $display("FAIL reset_data: got %h expected 000", bus.data_out); end
    n_checks++;
    if (bus.overrun !== 1'b0 || bus.frame_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_pulses: overrun=%b frame_err=%b expected 0 0", bus.overrun, bus.frame_err);
    end
  endtask

  // First frame_start lands in the first cycle with rst_n high.
  task automatic test_basic();
    rst_n = 1'b1;
    send_word(12'hA5C, 1'b1, 1'b1);
    check_output("basic");
    tick();
    n_checks++;
    if (bus.data_valid !== 1'b0) begin n_fail++; $display("FAIL basic_clear: data_valid=%b expected 0", bus.data_valid); end
    bus.data_ready = 1'b0;
  endtask

  task automatic test_overrun();
    int o0;
    send_word(12'h123, 1'b0, 1'b1);
    check_output("ovr_first");
    o0 = ovr_cnt;
    send_word(12'hFFF, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (ovr_cnt - o0 !== 1) begin n_fail++; $display("FAIL ovr_pulses: got %0d pulses expected 1", ovr_cnt - o0); end
    n_checks++;
    if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_width: overrun=%b expected 0 after one cycle", bus.overrun); end
    n_checks++;
    if (bus.data_valid !== 1'b1 || bus.data_out !== 12'h123) begin
      n_fail++; $display("FAIL ovr_hold: valid=%b data_out=%h expected 1 123", bus.data_valid, bus.data_out);
    end
  endtask

  task automatic test_back_to_back();
    int o0;
    o0 = ovr_cnt;
    send_word(12'h456, 1'b1, 1'b1);
    bus.data_ready = 1'b0;
    check_output("b2b");
    tick();
    n_checks++;
    if (ovr_cnt !== o0) begin n_fail++; $display("FAIL b2b_overrun: got %0d pulses expected 0", ovr_cnt - o0); end
    n_checks++;
    if (bus.data_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid_hold: got %b expected 1", bus.data_valid); end
    bus.data_ready = 1'b1;
    tick();
    bus.data_ready = 1'b0;
    n_checks++;
    if (bus.data_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_accept: data_valid=%b expected 0", bus.data_valid); end
  endtask

  task automatic test_frame_err();
    int f0;
    f0 = ferr_cnt;
    // frame_start with the counter still at 0 is not an abort
    bus.frame_start = 1'b1; tick(); tick();
    bus.frame_start = 1'b0;
    send_bits(make_frame(12'h5A5, 1'b0), 5, 1'b1, 1'b0);
    send_word(12'h800, 1'b0, 1'b1);
    check_output("ferr");
    tick();
    n_checks++;
    if (ferr_cnt - f0 !== 1) begin n_fail++; $display("FAIL ferr_pulses: got %0d pulses expected 1", ferr_cnt - f0); end
    bus.data_ready = 1'b1;
    tick();
    bus.data_ready = 1'b0;
  endtask

  task automatic test_reset_midframe();
    send_word(12'h3C7, 1'b0, 1'b1);
    check_output("rstmid_pre");
    send_bits(make_frame(12'h5A5, 1'b0), 7, 1'b1, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++;
    if (bus.data_valid !== 1'b0 || bus.data_out !== '0 || bus.overrun !== 1'b0 || bus.frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: valid=%b data=%h ovr=%b ferr=%b expected all 0",
               bus.data_valid, bus.data_out, bus.overrun, bus.frame_err);
    end
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
    n_checks++;
    if (bus.parity_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_parity: got %b expected 0", bus.parity_err); end
`endif
    for (int k = 0; k < 5; k++) begin
      bus.shift = 1'b1;
      bus.serial_data_in = 1'($urandom_range(0, 1));
      tick();
      n_checks++;
      if (bus.data_valid !== 1'b0) begin n_fail++; $display("FAIL idle_shift_%0d: data_valid=%b expected 0", k, bus.data_valid); end
    end
    bus.shift = 1'b0;
    tick();
    n_checks++;
    if (bus.data_valid !== 1'b0) begin n_fail++; $display("FAIL idle_shift_end: data_valid=%b expected 0", bus.data_valid); end
  endtask

`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
  task automatic test_parity();
    exp_q.push_back(make_exp(12'h001, 1'b0));
    send_bits(make_frame(12'h001, 1'b0), FN, 1'b1, 1'b0);
    check_output("parity_bad");
    bus.data_ready = 1'b1; tick(); bus.data_ready = 1'b0;
    exp_q.push_back(make_exp(12'h001, 1'b1));
    send_bits(make_frame(12'h001, 1'b1), FN, 1'b1, 1'b0);
    check_output("parity_good");
    bus.data_ready = 1'b1; tick(); bus.data_ready = 1'b0;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    bus.frame_start = 1'b0; bus.shift = 1'b0; bus.serial_data_in = 1'b0; bus.data_ready = 1'b0;
    test_reset();
    test_basic();
    test_overrun();
    test_back_to_back();
    test_frame_err();
    test_reset_midframe();
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
    test_parity();
`endif
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: %0d words never produced, expected 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_word_receiver.md
SERIAL_WORD_RECEIVER -- requirements
Module: serial_word_receiver

Interface
REQ-001 SHALL have parameter WIDTH, default 12, meaning data bits per frame.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port frame_start  input  1  marks the first bit of a frame; the transmitter loads its word in this cycle.
REQ-005 SHALL have port shift  input  1  bit strobe; serial_data_in is sampled when high.
REQ-006 SHALL have port serial_data_in  input  1  serial bit stream, MSB first.
REQ-007 SHALL have port data_ready  input  1  consumer accepts data_out when high together with data_valid.
REQ-008 SHALL have port data_out  output  WIDTH  last completed word.
REQ-009 SHALL have port data_valid  output  1  data_out holds an unconsumed word.
REQ-010 SHALL have port overrun  output  1  one-cycle pulse: a completed word was dropped.
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse: a partial frame was aborted by frame_start.

Function
REQ-012 SHALL implement two states: IDLE (no frame open) and RECV (frame open, bit counter active).
REQ-013 In IDLE, shift without frame_start SHALL be ignored.
REQ-014 frame_start in any state SHALL clear the bit counter and shift register, then enter RECV; if shift is also high in that cycle, serial_data_in SHALL be captured as the frame's first bit.
REQ-015 In RECV, each cycle with shift=1 SHALL shift serial_data_in into the LSB of the internal shift register, moving earlier bits toward the MSB, and increment the bit counter.
REQ-016 Frame length N SHALL be WIDTH shifts, or WIDTH+1 shifts when the parity feature is compiled in.
REQ-017 The N-th shift SHALL complete the frame, return the FSM to IDLE and offer the word to the output register.
REQ-018 data_valid SHALL rise on the clock edge after the sampling cycle of the final bit, giving 1-cycle latency.
REQ-019 data_out and data_valid SHALL hold stable while data_valid=1 and data_ready=0.
REQ-020 data_valid=1 and data_ready=1 SHALL clear data_valid on the next edge, unless a word completes in the same cycle.
REQ-021 A completion with data_ready=1 in the same cycle SHALL load the new word and keep data_valid=1.
REQ-022 A completion while data_valid=1 and data_ready=0 SHALL drop the new word, retain data_out, and pulse overrun for 1 cycle.
REQ-023 frame_start arriving in RECV with bit counter between 1 and N-1 SHALL pulse frame_err for 1 cycle; frame_start at counter 0 SHALL NOT.
REQ-024 A new frame SHALL be able to shift in while the previous word waits in data_out.
REQ-025 The bit counter SHALL be sized as clog2(WIDTH+2) bits and SHALL never wrap within a frame.

Reset
REQ-026 rst_n=0 at a clock edge SHALL force IDLE and clear the counter, shift register, data_out, data_valid, overrun, frame_err and parity_err to 0; this SHALL override all other inputs, including mid-frame.
REQ-027 The first frame_start SHALL be honoured in the first cycle with rst_n=1.

Configuration
REQ-028 Macro SERIAL_WORD_RECEIVER_PARITY_EN defined: the frame SHALL carry a trailing even-parity bit; output port parity_err (1 bit) SHALL be registered with data_out, be valid while data_valid=1, and be 1 when the XOR of WIDTH data bits and the parity bit is 1.
REQ-029 Macro SERIAL_WORD_RECEIVER_PARITY_EN undefined: frame SHALL be WIDTH bits, port parity_err SHALL be absent, and behaviour is otherwise identical.

Verification
REQ-030 Bench SHALL cover: frame_start+shift, then 11 more shifts of 0xA5C MSB first, data_ready=1 -> data_out=0xA5C and data_valid=1 one cycle after the 12th shift, cleared the following cycle.
REQ-031 Bench SHALL cover: word 0x123 held with data_ready=0, second frame 0xFFF completes -> overrun pulses once, data_out stays 0x123.
REQ-032 Bench SHALL cover: second frame 0x456 completes in the same cycle data_ready=1 accepts 0x123 -> data_out=0x456, data_valid stays 1, no overrun.
REQ-033 Bench SHALL cover: frame_start after 5 bits, then a full frame 0x800 -> one frame_err pulse, data_out=0x800.
REQ-034 Bench SHALL cover: rst_n=0 for 1 cycle after 7 bits -> all outputs 0; 5 further shifts without frame_start produce no data_valid.
REQ-035 Bench SHALL cover, with PARITY_EN: 0x001 with parity bit 0 -> parity_err=1; with parity bit 1 -> parity_err=0.
